aes_encrypt_iter: RTL and testbench
===================================

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 The block SHALL use the following parameters: KEY_WIDTH, default 128, cipher key width in bits (128/192/256).
REQ-002 The block SHALL use the following parameter: NR, default 10, number of rounds.
REQ-003 The block SHALL use the following parameter: NK, default 4, key length in 32-bit words.
REQ-004 Parameter combinations other than (128,10,4), (192,12,6) and (256,14,8) SHALL cause an elaboration error.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  plaintext/key offered.
- in_ready  out  1  block can accept.
- in_data  in  128  plaintext, byte 0 in bits [127:120].
- in_key  in  KEY_WIDTH  cipher key, word 0 in the MSBs.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext, FIPS-197 byte order.
- busy  out  1  high in any state other than IDLE.

Function
REQ-007 The FSM SHALL have four states, IDLE, KEXP, ROUND and DONE; encoding is free.
REQ-008 in_ready SHALL be high only in IDLE; an accept occurs at an edge where in_valid and in_ready are both high.
REQ-009 On accept, the block SHALL load state <= in_data XOR in_key[KEY_WIDTH-1 -: 128] and round counter <= 1.
REQ-010 On accept, the block SHALL compare in_key with the cached key: hit (cache valid and equal) -> ROUND; miss -> KEXP, load cached key, clear cache valid.
REQ-011 KEXP SHALL generate one key-schedule word w[i] per cycle for i = NK .. 4*(NR+1)-1, using RotWord/SubWord/Rcon for i mod NK == 0 and SubWord only for NK==8 with i mod 8 == 4.
REQ-012 KEXP SHALL last W = 4*(NR+1)-NK cycles (40/46/52); on the last word it SHALL set cache valid and enter ROUND.
REQ-013 ROUND SHALL perform one AES round per cycle with round key w[4r..4r+3]; rounds 1..NR-1 are full rounds, and round NR omits MixColumns.
REQ-014 After round NR, the block SHALL register out_data and enter DONE; out_valid SHALL be high exactly in DONE.
REQ-015 Latency from the accept edge to the first cycle with out_valid high SHALL be NR cycles on a hit and W+NR cycles on a miss.
REQ-016 In DONE, out_data SHALL stay stable while out_ready is low (no data loss under backpressure); when out_valid and out_ready are both high -> IDLE.
REQ-017 in_ready SHALL rise in the cycle after the output handshake; no overlap of blocks.
REQ-018 in_valid, in_data and in_key SHALL be ignored outside IDLE.
REQ-019 The round counter SHALL be ceil(log2(NR+1)) bits wide and SHALL not wrap; a value beyond NR is unreachable.

Reset
REQ-020 While rst is high at an edge, the block SHALL go to IDLE, clear cache valid, and drive out_valid=0, busy=0, in_ready=1 (after the edge), out_data=0.
REQ-021 Reset asserted mid-KEXP/ROUND/DONE SHALL abort the block with no output and SHALL force a key miss on the next accept.
REQ-022 Reset SHALL take priority over all handshakes in the same cycle.

Structure
REQ-023 Package aes_pkg SHALL hold the S-box table, the Rcon table, NB=4, and the state_t enum.
REQ-024 Sub-module aes_round SHALL be combinational: state in, round key in, final flag in, next state out.
REQ-025 The key schedule SHALL be a register array of 4*(NR+1) 32-bit words; there SHALL be no RAM inference requirement.

Verification
REQ-026 V1: KEY_WIDTH=128, key 2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734 -> out 3925841d02dc09fbdc118597196a0b32, out_valid at accept+50.
REQ-027 V2: V1 then same key, in 00112233445566778899aabbccddeeff with key 000102..0f -> miss; repeat same key/data -> 69c4e0d86a7b0430d8cdb78070b4c55a with latency 10 (hit).
REQ-028 V3: 192-bit key 000102..17, in 00112233..ff -> dda97ca4864cdfe06eaf70a0ec0d7191 at +58; 256-bit key 000102..1f, same in -> 8ea2b7ca516745bfeafc49904b496089 at +66.
REQ-029 V4: hold out_ready low 20 cycles in DONE -> out_valid and out_data stable, in_ready low; release -> single transfer, in_ready high on the next cycle.
REQ-030 V5: rst pulse during KEXP cycle 10 -> out_valid never asserts; next accept with the same key takes miss latency and gives the correct ciphertext.
REQ-031 V6: alternate two keys across 4 blocks -> every block misses; all ciphertexts match the reference model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES tables, constants and FSM state type.
// Used by the iterative encryptor and its round datapath.
package aes_pkg;

    localparam int NB = 4;

    typedef enum logic [1:0] {
        IDLE,
        KEXP,
        ROUND,
        DONE
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 0 is unused; the schedule starts at Rcon[1].
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. Byte n of the state sits at bits [127-8n -: 8].
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rkey,
    input  logic         i_final,
    output logic [127:0] o_state
);

    logic [7:0]   w_sb [16];
    logic [7:0]   w_sh [16];
    logic [127:0] w_sr;
    logic [127:0] w_mc;

    always_comb begin
        for (int n = 0; n < 16; n++) begin
            w_sb[n] = SBOX[i_state[127-8*n -: 8]];
        end
    end

    // Row r of column c comes from column (c + r) mod 4.
    always_comb begin
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sh[4*c+r] = w_sb[4*((c+r)%NB)+r];
            end
        end
    end

    always_comb begin
        w_sr = '0;
        w_mc = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(4*c+r) -: 8] = w_sh[4*c+r];
                w_mc[127-8*(4*c+r) -: 8] =
                    xtime(w_sh[4*c+r]) ^
                    xtime(w_sh[4*c+(r+1)%4]) ^ w_sh[4*c+(r+1)%4] ^
                    w_sh[4*c+(r+2)%4] ^ w_sh[4*c+(r+3)%4];
            end
        end
    end

    assign o_state = (i_final ? w_sr : w_mc) ^ i_rkey;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor, one round per cycle, with a cached
// expanded key that is rebuilt one word per cycle on a key change.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int KEY_WIDTH = 128,
    parameter int NR        = 10,
    parameter int NK        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_data,
    input  logic [KEY_WIDTH-1:0] in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_data,
    output logic                 busy
);

    localparam int NW  = 4 * (NR + 1);
    localparam int RW  = $clog2(NR + 1);
    localparam int KW  = $clog2(NW);
    localparam int KMW = $clog2(NK);

    generate
        if (!((KEY_WIDTH == 128 && NR == 10 && NK == 4) ||
              (KEY_WIDTH == 192 && NR == 12 && NK == 6) ||
              (KEY_WIDTH == 256 && NR == 14 && NK == 8))) begin : g_bad_cfg
            $error("aes_encrypt_iter: unsupported KEY_WIDTH/NR/NK");
        end
    endgenerate

    state_t               r_fsm;
    state_t               w_nxt;
    logic [127:0]         r_st;
    logic [127:0]         r_out;
    logic [RW-1:0]        r_rnd;
    logic [31:0]          r_w [NW];
    logic [KEY_WIDTH-1:0] r_key;
    logic                 r_kv;
    logic [KW-1:0]        r_ki;
    logic [KMW-1:0]       r_km;
    logic [3:0]           r_rc;

    logic                 w_hit;
    logic                 w_wlast;
    logic                 w_rlast;
    logic [31:0]          w_prev;
    logic [31:0]          w_tmp;
    logic [KW-1:0]        w_rb;
    logic [127:0]         w_rk;
    logic [127:0]         w_nst;

    assign w_hit   = r_kv && (in_key == r_key);
    assign w_wlast = (r_ki == KW'(NW - 1));
    assign w_rlast = (r_rnd == RW'(NR));
    assign w_prev  = r_w[r_ki - KW'(1)];
    assign w_rb    = KW'({r_rnd, 2'b00});
    assign w_rk    = {r_w[w_rb], r_w[w_rb | KW'(1)],
                      r_w[w_rb | KW'(2)], r_w[w_rb | KW'(3)]};

    // r_km tracks i mod NK and r_rc tracks i / NK for the word in flight.
    always_comb begin
        w_tmp = w_prev;
        unique case (1'b1)
            (r_km == '0):
                w_tmp = subword({w_prev[23:0], w_prev[31:24]}) ^ {RCON[r_rc], 24'h0};
            (NK == 8 && r_km == KMW'(4)):
                w_tmp = subword(w_prev);
            default: ;
        endcase
    end

    aes_round u_round (
        .i_state (r_st),
        .i_rkey  (w_rk),
        .i_final (w_rlast),
        .o_state (w_nst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_fsm;
        unique case (r_fsm)
            IDLE:    if (in_valid)  w_nxt = w_hit ? ROUND : KEXP;
            KEXP:    if (w_wlast)   w_nxt = ROUND;
            ROUND:   if (w_rlast)   w_nxt = DONE;
            DONE:    if (out_ready) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_fsm == IDLE);
        out_valid = (r_fsm == DONE);
        busy      = (r_fsm != IDLE);
    end

    assign out_data = r_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kv  <= 1'b0;
            r_out <= '0;
            r_st  <= '0;
            r_rnd <= '0;
            r_ki  <= '0;
            r_km  <= '0;
            r_rc  <= '0;
        end else begin
            unique case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_st  <= in_data ^ in_key[KEY_WIDTH-1 -: 128];
                        r_rnd <= RW'(1);
                        if (!w_hit) begin
                            r_key <= in_key;
                            r_kv  <= 1'b0;
                            r_ki  <= KW'(NK);
                            r_km  <= '0;
                            r_rc  <= 4'd1;
                        end
                    end
                end
                KEXP: begin
                    r_ki <= r_ki + KW'(1);
                    r_km <= (r_km == KMW'(NK - 1)) ? '0 : r_km + KMW'(1);
                    if (r_km == KMW'(NK - 1)) r_rc <= r_rc + 4'd1;
                    if (w_wlast) r_kv <= 1'b1;
                end
                ROUND: begin
                    r_st <= w_nst;
                    if (w_rlast) r_out <= w_nst;
                    else         r_rnd <= r_rnd + RW'(1);
                end
                default: ;
            endcase
        end
    end

    // Schedule array: first NK words straight from the key, rest built in KEXP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_fsm == IDLE && in_valid && !w_hit) begin
                for (int j = 0; j < NK; j++) begin
                    r_w[j] <= in_key[KEY_WIDTH-1-32*j -: 32];
                end
            end else if (r_fsm == KEXP) begin
                r_w[r_ki] <= r_w[r_ki - KW'(NK)] ^ w_tmp;
            end
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: 128/192/256 instances checked against
// FIPS-197 vectors and a byte-level AES model with its own S-box.
module tb_aes_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv   [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic         bz   [3];
    logic [127:0] idat [3];
    logic [127:0] odat [3];
    logic [255:0] ikey [3];

    logic [255:0] ck [3];
    bit           cv [3];
    logic [7:0]   sb [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_encrypt_iter #(.KEY_WIDTH(128), .NR(10), .NK(4)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(idat[0]), .in_key(ikey[0][255:128]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_data(odat[0]), .busy(bz[0])
    );

    aes_encrypt_iter #(.KEY_WIDTH(192), .NR(12), .NK(6)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(idat[1]), .in_key(ikey[1][255:64]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_data(odat[1]), .busy(bz[1])
    );

    aes_encrypt_iter #(.KEY_WIDTH(256), .NR(14), .NK(8)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(idat[2]), .in_key(ikey[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_data(odat[2]), .busy(bz[2])
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                    rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [127:0] ref_enc(input logic [255:0] key, input int nk,
                                             input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sb[s[(n%4) + 4*(((n/4) + (n%4)) % 4)]];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) begin
                        s[4*c+k] = gm(8'h02, t[4*c+k]) ^ gm(8'h03, t[4*c+(k+1)%4]) ^
                                   t[4*c+(k+2)%4] ^ t[4*c+(k+3)%4];
                    end
                end
            end else begin
                s = t;
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full block on DUT d; latency expectation comes from the bench's own cache view.
    task automatic blk(input int d, input logic [255:0] key, input logic [127:0] pt,
                       input logic [127:0] exp, input int hold, input bit junk,
                       input string tag);
        int           lat;
        int           elat;
        int           nk;
        logic [255:0] km;
        logic [127:0] held;
        nk   = 4 + 2 * d;
        km   = key & ({256{1'b1}} << (256 - 32 * nk));
        elat = nk + 6 + ((cv[d] && ck[d] == km) ? 0 : 4 * (nk + 7) - nk);
        lat  = 0;
        while (!ir[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/rdy"}, 128'(ir[d]), 128'(1));
        iv[d]   = 1'b1;
        idat[d] = pt;
        ikey[d] = key;
        @(posedge clk); #1;
        cv[d] = 1'b1;
        ck[d] = km;
        chk({tag, "/busy"}, 128'(bz[d]), 128'(1));
        lat = 0;
        while (!ov[d] && lat < 300) begin
            if (junk) begin
                iv[d]   = 1'b1;
                idat[d] = rnd256()[127:0];
                ikey[d] = rnd256();
            end else begin
                iv[d] = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        iv[d] = 1'b0;
        chk({tag, "/lat"}, 128'(lat), 128'(elat));
        chk({tag, "/data"}, odat[d], exp);
        held = odat[d];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_v"}, 128'(ov[d]), 128'(1));
            chk({tag, "/hold_d"}, odat[d], held);
            chk({tag, "/hold_r"}, 128'(ir[d]), 128'(0));
        end
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        chk({tag, "/ir_after"}, 128'(ir[d]), 128'(1));
        chk({tag, "/ov_after"}, 128'(ov[d]), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] k_fips;
        logic [255:0] k_seq;
        logic [255:0] ka;
        logic [255:0] kb;
        logic [255:0] k;
        logic [127:0] pt;
        logic [127:0] pt_seq;
        bit           seen;

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; idat[d] = '0; ikey[d] = '0;
            cv[d] = 1'b0; ck[d] = '0;
        end
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d/ir", d), 128'(ir[d]), 128'(1));
            chk($sformatf("rst%0d/ov", d), 128'(ov[d]), 128'(0));
            chk($sformatf("rst%0d/busy", d), 128'(bz[d]), 128'(0));
            chk($sformatf("rst%0d/od", d), odat[d], 128'h0);
        end

        k_fips = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k_seq  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        pt_seq = 128'h00112233445566778899aabbccddeeff;

        blk(0, k_fips, 128'h3243f6a8885a308d313198a2e0370734,
            128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0, "v1");
        blk(0, k_seq, pt_seq, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0, "v2miss");
        blk(0, k_seq, pt_seq, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0, "v2hit");
        blk(1, k_seq, pt_seq, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 0, 1'b0, "v3_192");
        blk(2, k_seq, pt_seq, 128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b0, "v3_256");
        blk(0, k_seq, pt_seq, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 20, 1'b0, "v4");

        iv[0]   = 1'b1;
        idat[0] = 128'h3243f6a8885a308d313198a2e0370734;
        ikey[0] = k_fips;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("v5/in_kexp", 128'(bz[0]), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) cv[d] = 1'b0;
        chk("v5/ir", 128'(ir[0]), 128'(1));
        chk("v5/busy", 128'(bz[0]), 128'(0));
        chk("v5/od", odat[0], 128'h0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ov[0]) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("v5/no_out", 128'(seen), 128'(0));
        blk(0, k_fips, 128'h3243f6a8885a308d313198a2e0370734,
            128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0, "v5after");

        for (int d = 0; d < 3; d++) begin
            ka = rnd256();
            kb = rnd256();
            for (int b = 0; b < 4; b++) begin
                k  = (b % 2 == 0) ? ka : kb;
                pt = rnd256()[127:0];
                blk(d, k, pt, ref_enc(k, 4 + 2 * d, pt), 0, b[0],
                    $sformatf("v6_d%0d_b%0d", d, b));
            end
            for (int b = 0; b < 2; b++) begin
                pt = rnd256()[127:0];
                blk(d, kb, pt, ref_enc(kb, 4 + 2 * d, pt), int'($urandom_range(0, 3)), 1'b1,
                    $sformatf("hit_d%0d_b%0d", d, b));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
